// File: rtl/redux_pkg.sv
// Shared Redux-V definitions: data-memory geometry and the copy-engine state encoding.
package redux_pkg;
  localparam int LARGURA_DADO = 8;
  localparam int LARGURA_END  = 8;

  typedef enum logic [1:0] {
    OCIOSO,
    LER,
    ESCREVER,
    FIM
  } estado_copia_t;
endpackage

// File: rtl/copiador_memoria_if.sv
// Data-memory port bundle: the master drives address/write data/enable, and the slave returns read data in the same cycle.
interface copiador_memoria_if #(
  parameter int LARGURA_DADO = redux_pkg::LARGURA_DADO,
  parameter int LARGURA_END  = redux_pkg::LARGURA_END
);
  logic                    mem_writeEnable;
  logic [LARGURA_END-1:0]  mem_endereco;
  logic [LARGURA_DADO-1:0] mem_dadoEntrada;
  logic [LARGURA_DADO-1:0] mem_dadoSaida;

  modport master (
    output mem_writeEnable,
    output mem_endereco,
    output mem_dadoEntrada,
    input  mem_dadoSaida
  );

  modport slave (
    input  mem_writeEnable,
    input  mem_endereco,
    input  mem_dadoEntrada,
    output mem_dadoSaida
  );
endinterface

// File: rtl/memoria_dados.sv
// Redux-V data memory: the read is combinational on endereco, and the write commits on the rising clk edge when writeEnable is set.
module memoria_dados
  import redux_pkg::*;
#(
  parameter int LARGURA_DADO = redux_pkg::LARGURA_DADO,
  parameter int LARGURA_END  = redux_pkg::LARGURA_END
) (
  input  logic                    clk,
  input  logic                    writeEnable,
  input  logic [LARGURA_END-1:0]  endereco,
  input  logic [LARGURA_DADO-1:0] dadoEntrada,
  output logic [LARGURA_DADO-1:0] dadoSaida
);
  logic [LARGURA_DADO-1:0] mem [2**LARGURA_END];

  always_ff @(posedge clk) begin
    if (writeEnable) mem[endereco] <= dadoEntrada;
  end

  assign dadoSaida = mem[endereco];
endmodule

// File: rtl/copiador_memoria.sv
// Ascending byte-copy engine mastering the data memory: each byte takes 2 cycles (LER then ESCREVER), and a one-cycle concluido pulse follows the last byte.
// start is only sampled in OCIOSO, so a request made while ocupado is dropped and is not queued.
module copiador_memoria
  import redux_pkg::*;
#(
  parameter int LARGURA_DADO = redux_pkg::LARGURA_DADO,
  parameter int LARGURA_END  = redux_pkg::LARGURA_END
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [LARGURA_END-1:0] origem,
  input  logic [LARGURA_END-1:0] destino,
  input  logic [LARGURA_END-1:0] tamanho,
  output logic                   ocupado,
  output logic                   concluido,
  copiador_memoria_if.master     bus
);
  localparam logic [LARGURA_END-1:0] UM = {{(LARGURA_END-1){1'b0}}, 1'b1};

  estado_copia_t           estado;
  estado_copia_t           proximo;
  logic [LARGURA_END-1:0]  origem_r;
  logic [LARGURA_END-1:0]  destino_r;
  logic [LARGURA_END-1:0]  tamanho_r;
  logic [LARGURA_END-1:0]  i;
  logic [LARGURA_DADO-1:0] buffer;
  logic                    ultimo;

  assign ultimo = (i == (tamanho_r - UM));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) estado <= OCIOSO;
    else     estado <= proximo;
  end

  // Moore decode: outputs depend only on the state and the captured registers, never on start.
  always_comb begin
    proximo             = estado;
    ocupado             = (estado != OCIOSO);
    concluido           = 1'b0;
    bus.mem_writeEnable = 1'b0;
    bus.mem_endereco    = '0;
    bus.mem_dadoEntrada = '0;
    case (estado)
      OCIOSO: begin
        if (start) proximo = (tamanho == '0) ? FIM : LER;
      end
      LER: begin
        bus.mem_endereco = origem_r + i;
        proximo          = ESCREVER;
      end
      ESCREVER: begin
        bus.mem_endereco    = destino_r + i;
        bus.mem_dadoEntrada = buffer;
        bus.mem_writeEnable = 1'b1;
        proximo             = ultimo ? FIM : LER;
      end
      FIM: begin
        concluido = 1'b1;
        proximo   = OCIOSO;
      end
      default: proximo = OCIOSO;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      origem_r  <= '0;
      destino_r <= '0;
      tamanho_r <= '0;
      i         <= '0;
      buffer    <= '0;
    end else begin
      case (estado)
        OCIOSO: begin
          if (start) begin
            origem_r  <= origem;
            destino_r <= destino;
            tamanho_r <= tamanho;
            i         <= '0;
          end
        end
        LER:      buffer <= bus.mem_dadoSaida;
        ESCREVER: if (!ultimo) i <= i + UM;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_copiador_memoria.sv
// Bench: the copy engine is wired to a real memoria_dados instance, and a bench-side mux on the memory port handles preload and readback.
module tb_copiador_memoria;
  import redux_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] origem = '0, destino = '0, tamanho = '0;
  logic       ocupado, concluido;

  always #5 clk = ~clk;

  copiador_memoria_if cif ();

  copiador_memoria dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .origem    (origem),
    .destino   (destino),
    .tamanho   (tamanho),
    .ocupado   (ocupado),
    .concluido (concluido),
    .bus       (cif.master)
  );

  logic       tb_sel = 1'b0, tb_we = 1'b0;
  logic [7:0] tb_addr = '0, tb_din = '0;
  logic       m_we;
  logic [7:0] m_addr, m_din, m_dout;

  assign m_we   = tb_sel ? tb_we   : cif.mem_writeEnable;
  assign m_addr = tb_sel ? tb_addr : cif.mem_endereco;
  assign m_din  = tb_sel ? tb_din  : cif.mem_dadoEntrada;
  assign cif.mem_dadoSaida = m_dout;

  memoria_dados mem_u (
    .clk         (clk),
    .writeEnable (m_we),
    .endereco    (m_addr),
    .dadoEntrada (m_din),
    .dadoSaida   (m_dout)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] ref_mem [256];
  int done_cycle, done_count, busy_cycles, bus_bad;
  logic [7:0] wr_addr[$], wr_dat[$], rd_addr[$];
  logic [7:0] exp_addr[$], exp_dat[$], exp_rd[$];

  task automatic tb_write(input logic [7:0] a, input logic [7:0] dv);
    @(negedge clk);
    tb_sel = 1'b1; tb_we = 1'b1; tb_addr = a; tb_din = dv;
    @(posedge clk);
    #1;
    tb_we = 1'b0; tb_sel = 1'b0;
    ref_mem[a] = dv;
  endtask

  task automatic mem_rd(input logic [7:0] a, output logic [7:0] dv);
    tb_sel = 1'b1; tb_we = 1'b0; tb_addr = a;
    #1;
    dv = m_dout;
    tb_sel = 1'b0;
  endtask

  task automatic mem_diff(output int n);
    logic [7:0] v;
    n = 0;
    @(negedge clk);
    for (int a = 0; a < 256; a++) begin
      mem_rd(8'(a), v);
      if (v !== ref_mem[a]) n++;
    end
  endtask

  // Reference: an ascending byte-by-byte copy on the model array, so overlap effects fall out naturally.
  task automatic model_copy(input logic [7:0] o, input logic [7:0] d, input logic [7:0] n);
    logic [7:0] ra, wa, b;
    exp_addr.delete(); exp_dat.delete(); exp_rd.delete();
    for (int j = 0; j < int'(n); j++) begin
      ra = 8'((int'(o) + j) % 256);
      wa = 8'((int'(d) + j) % 256);
      b  = ref_mem[ra];
      exp_rd.push_back(ra);
      exp_addr.push_back(wa);
      exp_dat.push_back(b);
      ref_mem[wa] = b;
    end
  endtask

  task automatic seq_diff(output int n);
    n = 0;
    if (wr_addr.size() != exp_addr.size()) n++;
    else
      for (int j = 0; j < wr_addr.size(); j++)
        if (wr_addr[j] !== exp_addr[j] || wr_dat[j] !== exp_dat[j]) n++;
    if (rd_addr.size() != exp_rd.size()) n++;
    else
      for (int j = 0; j < rd_addr.size(); j++)
        if (rd_addr[j] !== exp_rd[j]) n++;
  endtask

  task automatic run_copy(input logic [7:0] o, input logic [7:0] d, input logic [7:0] n,
                          input int alt_k, input logic [7:0] ao, input logic [7:0] ad,
                          input logic [7:0] an);
    bit fim_seen;
    done_cycle = -1; done_count = 0; busy_cycles = 0; bus_bad = 0;
    wr_addr.delete(); wr_dat.delete(); rd_addr.delete();
    @(negedge clk);
    origem = o; destino = d; tamanho = n; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    origem = 8'($urandom); destino = 8'($urandom); tamanho = 8'($urandom);
    fim_seen = 1'b0;
    for (int k = 1; k <= 1200; k++) begin
      @(negedge clk);
      if (concluido) begin
        done_count++;
        if (done_cycle < 0) done_cycle = k;
      end
      if (ocupado) busy_cycles++;
      if (cif.mem_writeEnable) begin
        wr_addr.push_back(cif.mem_endereco);
        wr_dat.push_back(cif.mem_dadoEntrada);
      end else if (ocupado && !concluido) begin
        rd_addr.push_back(cif.mem_endereco);
      end
      if ((!ocupado || concluido) &&
          (cif.mem_writeEnable || cif.mem_endereco != 0 || cif.mem_dadoEntrada != 0))
        bus_bad++;
      if (fim_seen) begin
        start = 1'b0;
        break;
      end
      if (k == alt_k) begin
        origem = ao; destino = ad; tamanho = an; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (concluido) fim_seen = 1'b1;
    end
    start = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (concluido) done_count++;
      if (cif.mem_writeEnable) begin
        wr_addr.push_back(cif.mem_endereco);
        wr_dat.push_back(cif.mem_dadoEntrada);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #1;
    checks++;
    if ({ocupado, concluido, cif.mem_writeEnable} !== 3'b000 ||
        cif.mem_endereco !== 8'h00 || cif.mem_dadoEntrada !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs got ocu=%b conc=%b we=%b end=%h din=%h want all 0",
               ocupado, concluido, cif.mem_writeEnable, cif.mem_endereco, cif.mem_dadoEntrada);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({ocupado, concluido, cif.mem_writeEnable} !== 3'b000) begin
      errors++;
      $display("FAIL reset_idle got ocu=%b conc=%b we=%b want 000", ocupado, concluido,
               cif.mem_writeEnable);
    end
  endtask

  task automatic test_basic;
    int nd;
    tb_write(8'h10, 8'hA1); tb_write(8'h11, 8'hB2);
    tb_write(8'h12, 8'hC3); tb_write(8'h13, 8'hD4);
    model_copy(8'h10, 8'h80, 8'd4);
    run_copy(8'h10, 8'h80, 8'd4, -1, 8'h0, 8'h0, 8'h0);
    checks++;
    if (done_cycle !== 9) begin
      errors++; $display("FAIL basic_done_cycle got %0d want 9", done_cycle);
    end
    checks++;
    if (done_count !== 1 || busy_cycles !== 9) begin
      errors++;
      $display("FAIL basic_pulse_busy got conc=%0d busy=%0d want 1 and 9", done_count, busy_cycles);
    end
    checks++;
    if (bus_bad !== 0) begin
      errors++; $display("FAIL basic_idle_bus got %0d nonzero cycles want 0", bus_bad);
    end
    seq_diff(nd);
    checks++;
    if (nd !== 0) begin
      errors++; $display("FAIL basic_bus_seq got %0d diffs want 0", nd);
    end
    mem_diff(nd);
    checks++;
    if (nd !== 0) begin
      errors++; $display("FAIL basic_mem got %0d bytes differ want 0", nd);
    end
  endtask

  task automatic test_zero_length;
    int nd;
    model_copy(8'h33, 8'h44, 8'd0);
    run_copy(8'h33, 8'h44, 8'd0, -1, 8'h0, 8'h0, 8'h0);
    checks++;
    if (done_cycle !== 1 || done_count !== 1) begin
      errors++;
      $display("FAIL zero_done got cycle=%0d count=%0d want 1 and 1", done_cycle, done_count);
    end
    checks++;
    if (busy_cycles !== 1) begin
      errors++; $display("FAIL zero_busy got %0d want 1", busy_cycles);
    end
    checks++;
    if (wr_addr.size() !== 0 || bus_bad !== 0) begin
      errors++;
      $display("FAIL zero_no_write got writes=%0d bad=%0d want 0 and 0", wr_addr.size(), bus_bad);
    end
    mem_diff(nd);
    checks++;
    if (nd !== 0) begin
      errors++; $display("FAIL zero_mem got %0d bytes differ want 0", nd);
    end
  endtask

  task automatic test_wrap;
    int nd;
    tb_write(8'hFE, 8'h11); tb_write(8'hFF, 8'h22); tb_write(8'h00, 8'h33);
    model_copy(8'hFE, 8'h40, 8'd3);
    run_copy(8'hFE, 8'h40, 8'd3, -1, 8'h0, 8'h0, 8'h0);
    checks++;
    if (done_cycle !== 7) begin
      errors++; $display("FAIL wrap_done_cycle got %0d want 7", done_cycle);
    end
    seq_diff(nd);
    checks++;
    if (nd !== 0) begin
      errors++; $display("FAIL wrap_bus_seq got %0d diffs want 0", nd);
    end
    mem_diff(nd);
    checks++;
    if (nd !== 0) begin
      errors++; $display("FAIL wrap_mem got %0d bytes differ want 0", nd);
    end
  endtask

  task automatic test_overlap;
    int nd;
    logic [7:0] v;
    tb_write(8'h20, 8'h5A); tb_write(8'h21, 8'h00);
    model_copy(8'h20, 8'h21, 8'd3);
    run_copy(8'h20, 8'h21, 8'd3, -1, 8'h0, 8'h0, 8'h0);
    @(negedge clk);
    for (int a = 8'h21; a <= 8'h23; a++) begin
      mem_rd(8'(a), v);
      checks++;
      if (v !== 8'h5A) begin
        errors++; $display("FAIL overlap_byte addr=%h got %h want 5a", a, v);
      end
    end
    mem_diff(nd);
    checks++;
    if (nd !== 0) begin
      errors++; $display("FAIL overlap_mem got %0d bytes differ want 0", nd);
    end
  endtask

  task automatic test_busy_start;
    int nd;
    model_copy(8'h50, 8'h90, 8'd4);
    run_copy(8'h50, 8'h90, 8'd4, 3, 8'h00, 8'h50, 8'd7);
    checks++;
    if (done_count !== 1 || done_cycle !== 9) begin
      errors++;
      $display("FAIL busy_pulse got count=%0d cycle=%0d want 1 and 9", done_count, done_cycle);
    end
    seq_diff(nd);
    checks++;
    if (nd !== 0) begin
      errors++; $display("FAIL busy_bus_seq got %0d diffs want 0", nd);
    end
    mem_diff(nd);
    checks++;
    if (nd !== 0) begin
      errors++; $display("FAIL busy_mem got %0d bytes differ want 0", nd);
    end
  endtask

  task automatic test_random;
    int nd;
    logic [7:0] o, d, n;
    for (int it = 0; it < 8; it++) begin
      o = 8'($urandom);
      d = 8'($urandom);
      n = (it == 0) ? 8'd255 : 8'($urandom_range(0, 24));
      model_copy(o, d, n);
      run_copy(o, d, n, -1, 8'h0, 8'h0, 8'h0);
      checks++;
      if (done_cycle !== 2 * int'(n) + 1 || done_count !== 1) begin
        errors++;
        $display("FAIL rand_done it=%0d got cycle=%0d count=%0d want %0d and 1",
                 it, done_cycle, done_count, 2 * int'(n) + 1);
      end
      seq_diff(nd);
      checks++;
      if (nd !== 0) begin
        errors++; $display("FAIL rand_bus_seq it=%0d got %0d diffs want 0", it, nd);
      end
      mem_diff(nd);
      checks++;
      if (nd !== 0) begin
        errors++; $display("FAIL rand_mem it=%0d got %0d bytes differ want 0", it, nd);
      end
    end
  endtask

  task automatic test_async_reset;
    int nd;
    logic [7:0] v;
    tb_write(8'h60, 8'h12); tb_write(8'h61, 8'h34);
    tb_write(8'hA0, 8'h00); tb_write(8'hA1, 8'hFF);
    @(negedge clk);
    origem = 8'h60; destino = 8'hA0; tamanho = 8'd4; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (cif.mem_writeEnable !== 1'b1 || cif.mem_endereco !== 8'hA1) begin
      errors++;
      $display("FAIL arst_pre got we=%b end=%h want 1 and a1", cif.mem_writeEnable, cif.mem_endereco);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (cif.mem_writeEnable !== 1'b0 || ocupado !== 1'b0) begin
      errors++;
      $display("FAIL arst_immediate got we=%b ocu=%b want 0 and 0", cif.mem_writeEnable, ocupado);
    end
    #1;
    rst = 1'b0;
    ref_mem[8'hA0] = 8'h12;
    @(negedge clk);
    mem_rd(8'hA0, v);
    checks++;
    if (v !== 8'h12) begin
      errors++; $display("FAIL arst_byte1 got %h want 12", v);
    end
    mem_rd(8'hA1, v);
    checks++;
    if (v !== 8'hFF) begin
      errors++; $display("FAIL arst_byte2 got %h want ff", v);
    end
    mem_diff(nd);
    checks++;
    if (nd !== 0) begin
      errors++; $display("FAIL arst_mem got %0d bytes differ want 0", nd);
    end
  endtask

  initial begin
    test_reset;
    for (int a = 0; a < 256; a++) tb_write(8'(a), 8'($urandom));
    test_basic;
    test_zero_length;
    test_wrap;
    test_overlap;
    test_busy_start;
    test_random;
    test_async_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/copiador_memoria.md
# copiador_memoria

- Byte-copy engine for Redux-V. It is the initiator side of the `memoria_dados` port: it drives `writeEnable`, `endereco` and `dadoEntrada`, and consumes `dadoSaida`.
- On a `start` pulse it copies `tamanho` bytes from `origem` to `destino`, one byte at a time.
- It sits beside the core as a memory master. It pulses `concluido` when the copy is finished.

## Interface
- `LARGURA_DADO`, 8: data word width; matches `memoria_dados`.
- `LARGURA_END`, 8: address width; 256-byte space.
- `clk`  in  1  system clock; rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `start`  in  1  copy request; sampled on `clk` only in OCIOSO.
- `origem`  in  LARGURA_END  source base address; captured at accepted `start`.
- `destino`  in  LARGURA_END  destination base address; captured at accepted `start`.
- `tamanho`  in  LARGURA_END  byte count, 0..255; captured at accepted `start`.
- `ocupado`  out  1  high whenever the state is not OCIOSO.
- `concluido`  out  1  one-cycle pulse in FIM.
- `mem_writeEnable`  out  1  connects to `memoria_dados.writeEnable`.
- `mem_endereco`  out  LARGURA_END  connects to `memoria_dados.endereco`.
- `mem_dadoEntrada`  out  LARGURA_DADO  connects to `memoria_dados.dadoEntrada`.
- `mem_dadoSaida`  in  LARGURA_DADO  connects to `memoria_dados.dadoSaida`.

## Operation
- Memory contract:
  - Read is combinational: `dadoSaida` = mem[`endereco`] within the same cycle.
  - Write commits on the rising `clk` edge while `writeEnable`=1.
- FSM has four states: OCIOSO, LER, ESCREVER, FIM.
  - OCIOSO: when `start`=1, capture `origem`/`destino`/`tamanho` into registers and clear index `i`.
    - If `tamanho`=0, go to FIM.
    - Otherwise go to LER.
  - LER: `mem_endereco`=`origem_r`+`i`, `mem_writeEnable`=0. At the clock edge, latch `mem_dadoSaida` into `buffer`, then go to ESCREVER.
  - ESCREVER: `mem_endereco`=`destino_r`+`i`, `mem_dadoEntrada`=`buffer`, `mem_writeEnable`=1. At the clock edge:
    - If `i`==`tamanho_r`-1, go to FIM.
    - Otherwise increment `i` and go to LER.
  - FIM: `concluido`=1, then go to OCIOSO.
- Outputs are Moore, decoded from the state and the registers only. There is no combinational path from `start` to any output.
- Address arithmetic is modulo 2^LARGURA_END; addresses wrap silently (0xFF+1 → 0x00).
- Copy direction is ascending only.
  - With overlapping regions where `destino` > `origem`, already-written bytes are re-read. The source pattern then repeats with period `destino`-`origem`. This is the defined behaviour, not an error.
- `start` asserted while `ocupado`=1 is ignored, with no queueing.
- Input changes after `start` is accepted have no effect on the copy in progress.
- In OCIOSO and FIM: `mem_writeEnable`=0, `mem_endereco`=0, `mem_dadoEntrada`=0.

## Timing
- Reset (async, immediate): state=OCIOSO.
  - All outputs 0: `ocupado`, `concluido`, `mem_writeEnable`, `mem_endereco`, `mem_dadoEntrada`.
  - `buffer`, `i` and the captured registers are 0.
- Reset mid-copy: `mem_writeEnable` drops without waiting for `clk`. Bytes already written stay written; there is no resume.
- Start is accepted at rising edge E0. For N≥1:
  - LER occupies cycles 1,3,…,2N-1.
  - ESCREVER occupies cycles 2,4,…,2N.
  - FIM is cycle 2N+1, and `concluido` is high only then.
  - `ocupado` is high in cycles 1..2N+1.
- For N=0: FIM is cycle 1, with no memory write.
- A new `start` is accepted at the edge that ends cycle 2N+2 (back in OCIOSO) at the earliest.
- Throughput: 2 cycles/byte.

## Structure
- Shared package `redux_pkg`:
  - state enum `estado_copia_t` {OCIOSO, LER, ESCREVER, FIM};
  - constants `LARGURA_DADO`=8 and `LARGURA_END`=8, reused by `memoria_dados`.
- No RTL sub-module; the single FSM plus datapath fits in one module.
- The bench top instantiates `copiador_memoria` wired to a real `memoria_dados` instance. Bytes are preloaded by a bench-side write phase that muxes the memory port.

## Test plan
- Basic copy:
  - Stimulus: preload mem[0x10..0x13]=0xA1,0xB2,0xC3,0xD4; start with `origem`=0x10, `destino`=0x80, `tamanho`=4.
  - Required: mem[0x80..0x83] equal those bytes; `concluido` high exactly in cycle 9; mem[0x84] unchanged.
- Zero length:
  - Stimulus: `tamanho`=0.
  - Required: `concluido` in cycle 1; `mem_writeEnable` never 1; `ocupado` high for 1 cycle.
- Wrap-around:
  - Stimulus: `origem`=0xFE, `destino`=0x40, `tamanho`=3, with mem[0xFE]=0x11, mem[0xFF]=0x22, mem[0x00]=0x33.
  - Required: mem[0x40..0x42]=0x11,0x22,0x33.
- Overlap:
  - Stimulus: mem[0x20]=0x5A, mem[0x21]=0x00; `origem`=0x20, `destino`=0x21, `tamanho`=3.
  - Required: mem[0x21..0x23]=0x5A.
- Busy start ignored:
  - Stimulus: re-pulse `start` with different operands at cycle 3 of a 4-byte copy.
  - Required: the original copy completes unchanged; there is exactly one `concluido` pulse.
- Async reset:
  - Stimulus: assert `rst` mid-ESCREVER of byte 2, between clock edges.
  - Required: `mem_writeEnable`=0 and `ocupado`=0 before the next edge; byte 2 is not written, byte 1 is.
